// File: rtl/mac_unit.sv
// ============================================================================
// mac_unit : pipelined signed multiply-accumulate with saturation and
//            output back-pressure.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mac_unit #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int PIPE   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] dataa,
   input  logic signed [DATA_W-1:0] datab,
   input  logic                     first,
   input  logic                     last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  result,
   output logic                     overflow
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

   generate
      if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
         $error("mac_unit: ACC_W must be >= 2*DATA_W");
      end
      if (DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
         $error("mac_unit: DATA_W must be in 4..32");
      end
      if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
         $error("mac_unit: PIPE must be in 1..4");
      end
   endgenerate

   logic w_stall;
   logic w_accept;
   logic r_out_valid;

   assign w_stall  = r_out_valid && !out_ready;
   assign in_ready = !w_stall;
   assign w_accept = in_valid && in_ready;

   // Operand capture stage; the multiplier pipeline starts from these registers.
   logic signed [DATA_W-1:0] r_a;
   logic signed [DATA_W-1:0] r_b;
   logic                     r_in_v;
   logic                     r_in_f;
   logic                     r_in_l;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_v <= 1'b0;
      end else if (!w_stall) begin
         r_in_v <= w_accept;
         if (w_accept) begin
            r_a    <= dataa;
            r_b    <= datab;
            r_in_f <= first;
            r_in_l <= last;
         end
      end
   end

   logic signed [PROD_W-1:0] r_prod [PIPE];
   logic        [PIPE-1:0]   r_pv;
   logic        [PIPE-1:0]   r_pf;
   logic        [PIPE-1:0]   r_pl;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pv <= '0;
      end else if (!w_stall) begin
         r_pv[0]   <= r_in_v;
         r_pf[0]   <= r_in_f;
         r_pl[0]   <= r_in_l;
         r_prod[0] <= PROD_W'(r_a) * PROD_W'(r_b);
         for (int i = 1; i < PIPE; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_pf[i]   <= r_pf[i-1];
            r_pl[i]   <= r_pl[i-1];
            r_prod[i] <= r_prod[i-1];
         end
      end
   end

   logic signed [ACC_W-1:0] r_acc;
   logic                    r_sticky;
   logic signed [ACC_W-1:0] r_result;
   logic                    r_overflow;

   logic signed [SUM_W-1:0] w_base;
   logic signed [SUM_W-1:0] w_prod_ext;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_sat;
   logic                    w_sat_hit;
   logic                    w_ovf;

   // One guard bit above the accumulator detects the out-of-range sum.
   always_comb begin
      w_base     = r_pf[PIPE-1] ? '0 : SUM_W'(r_acc);
      w_prod_ext = SUM_W'(r_prod[PIPE-1]);
      w_sum      = w_base + w_prod_ext;
      w_sat_hit  = w_sum[SUM_W-1] != w_sum[SUM_W-2];
      if (!w_sat_hit) begin
         w_sat = w_sum[ACC_W-1:0];
      end else if (w_sum[SUM_W-1]) begin
         w_sat = c_acc_min;
      end else begin
         w_sat = c_acc_max;
      end
      w_ovf = w_sat_hit || (!r_pf[PIPE-1] && r_sticky);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_result    <= '0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= r_pv[PIPE-1] && r_pl[PIPE-1];
         if (r_pv[PIPE-1]) begin
            if (r_pl[PIPE-1]) begin
               r_result   <= w_sat;
               r_overflow <= w_ovf;
               r_acc      <= '0;
               r_sticky   <= 1'b0;
            end else begin
               r_acc      <= w_sat;
               r_sticky   <= w_ovf;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/mac_unit.md
MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 Parameter DATA_W, default 16, signed operand width (range 4..32).
REQ-002 Parameter ACC_W, default 40, accumulator/result width; ACC_W >= 2*DATA_W; elaboration fails otherwise.
REQ-003 Parameter PIPE, default 2, multiplier pipeline stages (range 1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 dataa  input  DATA_W  signed operand A.
REQ-009 datab  input  DATA_W  signed operand B.
REQ-010 first  input  1  beat starts a new accumulation.
REQ-011 last  input  1  beat ends the current accumulation.
REQ-012 out_valid  output  1  result holds a completed accumulation.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 result  output  ACC_W  signed accumulated sum.
REQ-015 overflow  output  1  saturation occurred during this accumulation.

Function
REQ-016 A beat is accepted when in_valid && in_ready at a rising edge; otherwise dataa/datab/first/last are ignored.
REQ-017 Product = signed dataa * signed datab, full 2*DATA_W bits, sign-extended to ACC_W; no truncation.
REQ-018 The product and its first/last/valid tags traverse exactly PIPE register stages before the accumulate stage.
REQ-019 Accumulate stage: if tag first, acc = product; else acc = acc + product; result saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-020 Sticky overflow flag: set when any add in the current accumulation saturates; cleared/reloaded (to 0) on a first beat.
REQ-021 A beat without first after reset, or after a completed accumulation, accumulates onto acc = 0.
REQ-022 On a last-tagged beat at the accumulate stage, result and overflow load the final saturated sum and flag, out_valid sets, and acc clears to 0.
REQ-023 first && last on the same beat yields result = that single product.
REQ-024 Latency: beat with last accepted at edge k, no stall -> out_valid high after edge k+PIPE+1.
REQ-025 Throughput one beat per cycle; back-to-back accumulations (last beat followed next cycle by first beat) incur no bubble.
REQ-026 out_valid clears at an edge where out_ready is high, unless a new last beat completes at that same edge, in which case out_valid stays high with the new result.
REQ-027 Stall = out_valid && !out_ready; during stall every pipeline stage, acc, and result hold; in_ready = !stall (combinational).
REQ-028 No beat, partial sum, or result is dropped or duplicated under any out_ready pattern.
REQ-029 result and overflow are stable while out_valid && !out_ready.

Reset
REQ-030 While rst is high at an edge, all pipeline valids, acc, result, and overflow clear to 0, and out_valid = 0; in_ready = 1 from the cycle after.
REQ-031 Reset mid-accumulation discards the partial sum and all in-flight beats; the next accumulation is unaffected.

Verification (DATA_W=16, ACC_W=40, PIPE=2 unless stated)
REQ-032 Single beat 1*2, first=last=1, out_ready=1 -> out_valid 3 cycles after acceptance, result=2, overflow=0.
REQ-033 Vector (3,4),(-5,6),(7,-8),(100,100) with first on beat 0 and last on beat 3 -> result=9926, one out_valid pulse.
REQ-034 out_ready held low 5 cycles with result pending and in_valid=1 -> in_ready=0, result stable, no beat lost; correct next result after release.
REQ-035 ACC_W=33: 4 beats of (-32768,-32768) -> result=4294967295, overflow=1; following vector 2*3 -> result=6, overflow=0.
REQ-036 rst pulsed after beat 2 of a 4-beat vector -> all outputs 0; next vector (2,2),(3,3) -> result=13.
REQ-037 Two back-to-back vectors (1,1),(2,2) | (5,5) with continuous in_valid -> results 5 then 25 on consecutive cycles.
